// File: rtl/vram_blitter.sv
// ============================================================================
//  Module   : vram_blitter
//  Purpose  : Text-mode VRAM command engine (clear, scroll up/down, row fill)
//             driving a shared, externally granted VRAM write port.
//  Options  : VRAM_BLIT_SCROLL_DOWN_EN enables the SCROLL_DOWN command.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_blitter #(
    parameter logic [16:0] BASE = 17'hF000,
    parameter int          COLS = 80,
    parameter int          ROWS = 25
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic [1:0]  cmd,
    input  logic [4:0]  cmd_row,
    input  logic [7:0]  fill_char,
    input  logic [7:0]  fill_attr,
    output logic        busy,
    output logic        done,
    output logic [16:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_gnt
);

    localparam logic [11:0] C_ROWB  = 12'(COLS * 2);
    localparam logic [11:0] C_TOTAL = 12'(ROWS * COLS * 2);
    localparam logic [11:0] C_COPY  = C_TOTAL - C_ROWB;
    localparam logic [4:0]  C_ROWS  = 5'(ROWS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_WRITE = 3'd3,
        S_FILL  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t      state_q;
    logic        busy_q, done_q, we_q, down_q, lat_first_q;
    logic [16:0] addr_q;
    logic [7:0]  wdata_q, char_q, attr_q, rdata_q;
    logic [11:0] src_q, dst_q, copy_last_q, fill_idx_q, fill_last_q;

    logic [11:0] w_row_base, w_src_next, w_dst_next, w_fill_next;

    assign w_row_base  = 12'(cmd_row) * C_ROWB;
    assign w_src_next  = down_q ? src_q - 12'd1 : src_q + 12'd1;
    assign w_dst_next  = down_q ? dst_q - 12'd1 : dst_q + 12'd1;
    assign w_fill_next = fill_idx_q + 12'd1;

    function automatic logic [16:0] addr_of(input logic [11:0] idx);
        return BASE + {5'd0, idx};
    endfunction

    function automatic logic [7:0] pattern(input logic [11:0] idx,
                                           input logic [7:0] ch,
                                           input logic [7:0] at);
        return idx[0] ? at : ch;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 17'd0;
            wdata_q     <= 8'd0;
            down_q      <= 1'b0;
            lat_first_q <= 1'b0;
            char_q      <= 8'd0;
            attr_q      <= 8'd0;
            rdata_q     <= 8'd0;
            src_q       <= 12'd0;
            dst_q       <= 12'd0;
            copy_last_q <= 12'd0;
            fill_idx_q  <= 12'd0;
            fill_last_q <= 12'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_start) begin
                        char_q <= fill_char;
                        attr_q <= fill_attr;
                        busy_q <= 1'b1;
                        if (cmd == 2'd0) begin
                            state_q     <= S_FILL;
                            fill_idx_q  <= 12'd0;
                            fill_last_q <= C_TOTAL - 12'd1;
                            addr_q      <= addr_of(12'd0);
                            wdata_q     <= fill_char;
                            we_q        <= 1'b1;
                        end else if (cmd == 2'd1) begin
                            state_q     <= S_READ;
                            down_q      <= 1'b0;
                            src_q       <= C_ROWB;
                            dst_q       <= 12'd0;
                            copy_last_q <= C_COPY - 12'd1;
                            fill_idx_q  <= C_COPY;
                            fill_last_q <= C_TOTAL - 12'd1;
                            addr_q      <= addr_of(C_ROWB);
                            we_q        <= 1'b0;
`ifdef VRAM_BLIT_SCROLL_DOWN_EN
                        end else if (cmd == 2'd2) begin
                            state_q     <= S_READ;
                            down_q      <= 1'b1;
                            src_q       <= C_COPY - 12'd1;
                            dst_q       <= C_TOTAL - 12'd1;
                            copy_last_q <= C_ROWB;
                            fill_idx_q  <= 12'd0;
                            fill_last_q <= C_ROWB - 12'd1;
                            addr_q      <= addr_of(C_COPY - 12'd1);
                            we_q        <= 1'b0;
`endif
                        end else if (cmd == 2'd3 && cmd_row < C_ROWS) begin
                            state_q     <= S_FILL;
                            fill_idx_q  <= w_row_base;
                            fill_last_q <= w_row_base + C_ROWB - 12'd1;
                            addr_q      <= addr_of(w_row_base);
                            wdata_q     <= pattern(w_row_base, fill_char, fill_attr);
                            we_q        <= 1'b1;
                        end else begin
                            // Nothing to touch: report completion straight away.
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                            we_q    <= 1'b0;
                        end
                    end
                end
                S_READ: begin
                    if (mem_gnt) begin
                        state_q     <= S_LATCH;
                        lat_first_q <= 1'b1;
                    end
                end
                S_LATCH: begin
                    // Read data is only valid in the first LATCH cycle; keep it across stalls.
                    if (lat_first_q) begin
                        rdata_q     <= mem_rdata;
                        lat_first_q <= 1'b0;
                    end
                    if (mem_gnt) begin
                        state_q <= S_WRITE;
                        addr_q  <= addr_of(dst_q);
                        wdata_q <= lat_first_q ? mem_rdata : rdata_q;
                        we_q    <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (mem_gnt) begin
                        if (dst_q == copy_last_q) begin
                            state_q <= S_FILL;
                            addr_q  <= addr_of(fill_idx_q);
                            wdata_q <= pattern(fill_idx_q, char_q, attr_q);
                        end else begin
                            state_q <= S_READ;
                            src_q   <= w_src_next;
                            dst_q   <= w_dst_next;
                            addr_q  <= addr_of(w_src_next);
                            we_q    <= 1'b0;
                        end
                    end
                end
                S_FILL: begin
                    if (mem_gnt) begin
                        if (fill_idx_q == fill_last_q) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                            we_q    <= 1'b0;
                        end else begin
                            fill_idx_q <= w_fill_next;
                            addr_q     <= addr_of(w_fill_next);
                            wdata_q    <= pattern(w_fill_next, char_q, attr_q);
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_we      = we_q;

endmodule

`default_nettype wire

// File: tb/tb_vram_blitter.sv
// ============================================================================
//  Module   : tb_vram_blitter
//  Purpose  : Self-checking bench for vram_blitter against a byte-array model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_blitter;

    localparam int NB   = 4000;
    localparam int ROWB = 160;
    localparam logic [16:0] BASE = 17'hF000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_start = 1'b0;
    logic [1:0]  cmd = 2'd0;
    logic [4:0]  cmd_row = 5'd0;
    logic [7:0]  fill_char = 8'd0, fill_attr = 8'd0;
    logic        busy, done, mem_we;
    logic [16:0] mem_address;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'd0;
    logic        mem_gnt = 1'b1;

    logic [7:0] vram [NB];
    logic [7:0] expv [NB];

    int n_cmp = 0, n_bad = 0;
    int wr_cnt = 0, oob_cnt = 0, unstable_cnt = 0, we_idle_cnt = 0;

    vram_blitter dut (
        .clock(clk), .reset(rst), .cmd_start(cmd_start), .cmd(cmd),
        .cmd_row(cmd_row), .fill_char(fill_char), .fill_attr(fill_attr),
        .busy(busy), .done(done), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .mem_gnt(mem_gnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // VRAM behaviour: granted writes land, granted reads return data next cycle.
    always @(posedge clk) begin
        int a;
        a = int'(mem_address) - int'(BASE);
        if (!rst && mem_gnt && mem_we) begin
            wr_cnt++;
            if (a >= 0 && a < NB) vram[a] = mem_wdata;
            else oob_cnt++;
        end else if (!rst && mem_gnt && busy) begin
            mem_rdata <= (a >= 0 && a < NB) ? vram[a] : 8'h00;
        end
    end

    // Bus must hold still after every non-granted cycle of a command.
    logic [16:0] p_addr;
    logic [7:0]  p_wdata;
    logic        p_we, p_gnt, p_busy;
    logic        p_valid = 1'b0;
    always @(negedge clk) begin
        if (p_valid && !rst && p_busy && busy && !p_gnt &&
            (mem_address != p_addr || mem_wdata != p_wdata || mem_we != p_we))
            unstable_cnt++;
        if (!rst && mem_we && !busy) we_idle_cnt++;
        p_addr = mem_address; p_wdata = mem_wdata; p_we = mem_we;
        p_gnt = mem_gnt; p_busy = busy; p_valid = !rst;
    end

    function automatic logic [7:0] fbyte(input int i, input logic [7:0] ch, input logic [7:0] at);
        return (i % 2 == 1) ? at : ch;
    endfunction

    // Expected screen after a command, plus copy/fill byte counts and first access.
    task automatic model(input int c, input int row, input logic [7:0] ch, input logic [7:0] at,
                         output int ncopy, output int nfill, output int first_idx, output int first_we);
        ncopy = 0; nfill = 0; first_idx = -1; first_we = 0;
        case (c)
            0: begin
                for (int i = 0; i < NB; i++) expv[i] = fbyte(i, ch, at);
                nfill = NB; first_idx = 0; first_we = 1;
            end
            1: begin
                for (int i = 0; i < NB - ROWB; i++) expv[i] = expv[i + ROWB];
                for (int i = NB - ROWB; i < NB; i++) expv[i] = fbyte(i, ch, at);
                ncopy = NB - ROWB; nfill = ROWB; first_idx = ROWB; first_we = 0;
            end
            2: begin
`ifdef VRAM_BLIT_SCROLL_DOWN_EN
                for (int i = NB - 1; i >= ROWB; i--) expv[i] = expv[i - ROWB];
                for (int i = 0; i < ROWB; i++) expv[i] = fbyte(i, ch, at);
                ncopy = NB - ROWB; nfill = ROWB; first_idx = NB - ROWB - 1; first_we = 0;
`endif
            end
            default: begin
                if (row < 25) begin
                    for (int i = row * ROWB; i < (row + 1) * ROWB; i++) expv[i] = fbyte(i, ch, at);
                    nfill = ROWB; first_idx = row * ROWB; first_we = 1;
                end
            end
        endcase
    endtask

    task automatic preload();
        for (int i = 0; i < NB; i++) begin
            vram[i] = 8'(i / ROWB);
            expv[i] = 8'(i / ROWB);
        end
    endtask

    task automatic cmp_vram(input string tag);
        int bad = 0;
        for (int i = 0; i < NB; i++) if (vram[i] !== expv[i]) bad++;
        check_eq({tag, "_vram_bad_bytes"}, bad, 0);
    endtask

    // Entered and left at posedge+1. Latency counts cycles from the start
    // cycle to the first cycle busy is low again; done is the cycle before.
    task automatic run_cmd(input string tag, input int c, input int row,
                           input logic [7:0] ch, input logic [7:0] at,
                           input bit rnd, input bit inject);
        int ncopy, nfill, fidx, fwe, lat, wr0, k, done_k, idle_k, pulses;
        model(c, row, ch, at, ncopy, nfill, fidx, fwe);
        lat = (ncopy + nfill == 0) ? 2 : 3 * ncopy + nfill + 2;
        wr0 = wr_cnt;
        cmd_start = 1'b1; cmd = 2'(c); cmd_row = 5'(row);
        fill_char = ch; fill_attr = at; mem_gnt = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0; cmd = 2'($urandom); cmd_row = 5'($urandom);
        fill_char = 8'($urandom); fill_attr = 8'($urandom);
        k = 1; done_k = -1; idle_k = -1; pulses = 0;
        while (idle_k < 0 && k < 40000) begin
            mem_gnt   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cmd_start = inject && (k == 50);
            @(negedge clk);
            if (k == 1) begin
                check_eq({tag, "_busy_t1"}, int'(busy), 1);
                check_eq({tag, "_we_t1"}, int'(mem_we), fwe);
                if (fidx >= 0)
                    check_eq({tag, "_addr_t1"}, int'(mem_address), int'(BASE) + fidx);
            end
            if (done) begin
                pulses++;
                if (done_k < 0) done_k = k;
            end
            if (!busy) idle_k = k;
            @(posedge clk); #1;
            k++;
        end
        cmd_start = 1'b0; mem_gnt = 1'b1;
        if (!rnd) begin
            check_eq({tag, "_latency"}, idle_k, lat);
            check_eq({tag, "_done_cycle"}, done_k, lat - 1);
        end else begin
            check_eq({tag, "_done_before_idle"}, done_k, idle_k - 1);
        end
        check_eq({tag, "_done_pulses"}, pulses, 1);
        check_eq({tag, "_writes"}, wr_cnt - wr0, ncopy + nfill);
        cmp_vram(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int seen;
        for (int i = 0; i < NB; i++) begin vram[i] = 8'h00; expv[i] = 8'h00; end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_we", int'(mem_we), 0);
        check_eq("rst_addr", int'(mem_address), 0);
        check_eq("rst_wdata", int'(mem_wdata), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_cmd("clear", 0, 0, 8'h20, 8'h17, 1'b0, 1'b0);
        check_eq("clear_first_byte", int'(vram[0]), 8'h20);
        check_eq("clear_last_byte", int'(vram[NB-1]), 8'h17);

        preload();
        run_cmd("scroll_up", 1, 0, 8'h00, 8'h07, 1'b0, 1'b0);
        check_eq("su_row0", int'(vram[0]), 1);
        check_eq("su_row23", int'(vram[23*ROWB]), 24);

        preload();
        run_cmd("scroll_down", 2, 0, 8'h41, 8'h1E, 1'b0, 1'b0);

        run_cmd("fill_row24", 3, 24, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        run_cmd("fill_row31", 3, 31, 8'h55, 8'hAA, 1'b0, 1'b0);

        preload();
        run_cmd("scroll_up_rnd", 1, 0, 8'h00, 8'h07, 1'b1, 1'b1);

        for (int n = 0; n < 6; n++)
            run_cmd("fill_rnd", 3, int'($urandom_range(0, 31)), 8'($urandom), 8'($urandom), 1'b1, 1'b0);

        // Reset partway through a CLEAR.
        seen = 0;
        cmd_start = 1'b1; cmd = 2'd0; fill_char = 8'h33; fill_attr = 8'h44;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        for (int k = 1; k < 500; k++) begin
            @(negedge clk); if (done) seen++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk); if (done) seen++;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_we", int'(mem_we), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); if (done) seen++;
            @(posedge clk); #1;
        end
        check_eq("midrst_no_done", seen, 0);
        check_eq("midrst_partial", int'(vram[100]), 8'h33);
        run_cmd("clear_after_rst", 0, 0, 8'h20, 8'h07, 1'b0, 1'b0);

        check_eq("stall_stability", unstable_cnt, 0);
        check_eq("out_of_range_writes", oob_cnt, 0);
        check_eq("we_while_idle", we_idle_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
